// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, slave FSM state type and transfer-decoding helpers
// used by the SRAM responder.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } slv_state_e;

  // Sizes above a word, and accesses not naturally aligned to their size, are rejected.
  function automatic logic xfer_legal(input logic [2:0] size, input logic [1:0] off);
    case (size)
      HSIZE_BYTE: return 1'b1;
      HSIZE_HALF: return !off[0];
      HSIZE_WORD: return off == 2'b00;
      default:    return 1'b0;
    endcase
  endfunction

  // Little-endian lane selection for a legal transfer.
  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] off);
    case (size)
      HSIZE_BYTE: return 4'b0001 << off;
      HSIZE_HALF: return off[1] ? 4'b1100 : 4'b0011;
      default:    return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_mem_array.sv
// Word-organised SRAM with per-byte write enables and a combinational read port.
// Contents have no reset so they survive a bus reset.
module ahb_mem_array #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (be[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite SRAM responder: registers the address phase, optionally stalls with
// wait states, and answers illegal sizes/alignments with the two-cycle ERROR.
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hreadyin,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic        hresp
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  slv_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [1:0]        off_q, off_d;
  logic [2:0]        size_q, size_d;
  logic              write_q, write_d;

  logic        can_accept;
  logic        accept;
  logic        legal;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        unused_bits;

  // WAIT and ERR1 hold HREADY low, so no new address phase can complete there.
  assign can_accept = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
  assign accept     = can_accept && hsel && htrans[1] && hreadyin;
  assign legal      = xfer_legal(hsize, haddr[1:0]);
  assign unused_bits = ^{haddr[31:ADDR_W+2], htrans[0]};

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      idx_q   <= '0;
      off_q   <= 2'b00;
      size_q  <= 3'd0;
      write_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      off_q   <= off_d;
      size_q  <= size_d;
      write_q <= write_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    off_d   = off_q;
    size_d  = size_q;
    write_d = write_q;
    if (accept) begin
      idx_d   = haddr[ADDR_W+1:2];
      off_d   = haddr[1:0];
      size_d  = hsize;
      write_d = hwrite;
    end
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_DATA;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        state_d = ST_IDLE;
        if (accept) begin
          if (!legal) begin
            state_d = ST_ERR1;
          end else if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
    endcase
  end

  always_comb begin
    hreadyout = 1'b1;
    hresp     = HRESP_OKAY;
    hrdata    = 32'h0;
    case (state_q)
      ST_WAIT: hreadyout = 1'b0;
      ST_DATA: hrdata = rdata;
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
      end
      ST_ERR2: hresp = HRESP_ERROR;
      default: ;
    endcase
  end

  // The write lands on the edge that closes the data phase, which is also the edge
  // that opens the following read's data phase, so reads never need forwarding.
  assign be = (state_q == ST_DATA && write_q) ? byte_en(size_q, off_q) : 4'b0000;

  ahb_mem_array #(
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk  (hclk),
    .addr (idx_q),
    .be   (be),
    .wdata(hwdata),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: a zero-wait and a three-wait instance share one bus,
// with expected data-phase results queued at address phase and popped on completion.
module tb_ahb_slave_mem;
  import ahb_pkg::*;

  typedef struct {
    logic        rd;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic        hclk = 1'b0;
  logic        hreset = 1'b1;
  logic        hsel0 = 1'b0;
  logic        hsel3 = 1'b0;
  logic        hwrite = 1'b0;
  logic [1:0]  htrans = HTRANS_IDLE;
  logic [2:0]  hsize = HSIZE_WORD;
  logic [31:0] haddr = 32'h0;
  logic [31:0] hwdata = 32'h0;

  logic [31:0] hrdata0, hrdata3;
  logic        hreadyout0, hreadyout3, hresp0, hresp3;
  logic        hreadyin;
  logic [31:0] hrdata;
  logic        hresp;

  assign hreadyin = hreadyout0 & hreadyout3;
  assign hrdata   = hrdata0 | hrdata3;
  assign hresp    = hresp0 | hresp3;

  always #5 hclk = ~hclk;

  ahb_slave_mem #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hreadyin(hreadyin),
    .hrdata(hrdata0), .hreadyout(hreadyout0), .hresp(hresp0)
  );

  ahb_slave_mem #(.ADDR_W(8), .WAIT_CYCLES(3)) dut3 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel3), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hreadyin(hreadyin),
    .hrdata(hrdata3), .hreadyout(hreadyout3), .hresp(hresp3)
  );

  // One bus cycle: drive just after the rising edge, return at the falling edge for sampling.
  task automatic cyc(input logic s0, input logic s3, input logic [1:0] tr, input logic wr,
                     input logic [2:0] sz, input logic [31:0] ad, input logic [31:0] wd);
    @(posedge hclk);
    #1;
    hsel0 = s0; hsel3 = s3; htrans = tr; hwrite = wr; hsize = sz; haddr = ad; hwdata = wd;
    @(negedge hclk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge hclk);
    checks++;
    if ({hreadyin, hresp} !== 2'b10) begin
      errors++;
      $display("FAIL reset_handshake: ready/resp=%b%b expected 10", hreadyin, hresp);
    end
    checks++;
    if (hrdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_hrdata: got %h expected 00000000", hrdata);
    end
    @(posedge hclk);
    #1 hreset = 1'b0;
    @(negedge hclk);
  endtask

  task automatic test_word_rw();
    exp_t e;
    cyc(1, 0, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h10, 32'h0);
    exp_q.push_back('{1'b0, 1'b0, 32'h0});
    cyc(0, 0, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'hDEADBEEF);
    e = exp_q.pop_front();
    checks++;
    if ({hreadyin, hresp} !== {1'b1, e.err}) begin
      errors++;
      $display("FAIL word_write: ready/resp=%b%b expected 1%b", hreadyin, hresp, e.err);
    end
    cyc(1, 0, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h10, 32'h0);
    exp_q.push_back('{1'b1, 1'b0, 32'hDEADBEEF});
    cyc(0, 0, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'h0);
    e = exp_q.pop_front();
    checks++;
    if ({hreadyin, hresp, hrdata} !== {1'b1, e.err, e.data}) begin
      errors++;
      $display("FAIL word_read: ready=%b resp=%b data=%h expected ready=1 resp=%b data=%h",
               hreadyin, hresp, hrdata, e.err, e.data);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    cyc(1, 0, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h44, 32'h0);
    exp_q.push_back('{1'b0, 1'b0, 32'h0});
    cyc(1, 0, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h44, 32'hCAFEF00D);
    exp_q.push_back('{1'b1, 1'b0, 32'hCAFEF00D});
    e = exp_q.pop_front();
    checks++;
    if ({hreadyin, hresp} !== {1'b1, e.err}) begin
      errors++;
      $display("FAIL b2b_write: ready/resp=%b%b expected 1%b", hreadyin, hresp, e.err);
    end
    cyc(0, 0, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'h0);
    e = exp_q.pop_front();
    checks++;
    if ({hreadyin, hresp, hrdata} !== {1'b1, e.err, e.data}) begin
      errors++;
      $display("FAIL b2b_read: ready=%b resp=%b data=%h expected ready=1 resp=%b data=%h",
               hreadyin, hresp, hrdata, e.err, e.data);
    end
  endtask

  task automatic test_byte_lanes();
    exp_t        e;
    logic [31:0] ad [4];
    logic [2:0]  sz [4];
    logic        wr [4];
    logic [31:0] wd [4];
    logic [31:0] pw;
    ad = '{32'h20, 32'h21, 32'h22, 32'h20};
    sz = '{HSIZE_BYTE, HSIZE_BYTE, HSIZE_HALF, HSIZE_WORD};
    wr = '{1'b1, 1'b1, 1'b1, 1'b0};
    wd = '{32'h0000_0011, 32'h0000_2200, 32'h4433_0000, 32'h0};
    for (int i = 0; i <= 4; i++) begin
      pw = 32'h0;
      if (i > 0) pw = wd[i-1];
      if (i < 4) cyc(1, 0, HTRANS_NONSEQ, wr[i], sz[i], ad[i], pw);
      else       cyc(0, 0, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, pw);
      if (i > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (hreadyin !== 1'b1 || hresp !== e.err || (e.rd && hrdata !== e.data)) begin
          errors++;
          $display("FAIL byte_lanes[%0d]: ready=%b resp=%b data=%h expected ready=1 resp=%b data=%h",
                   i - 1, hreadyin, hresp, hrdata, e.err, e.data);
        end
      end
      if (i < 4) exp_q.push_back('{!wr[i], 1'b0, 32'h4433_2211});
    end
  endtask

  task automatic test_wait_states();
    exp_t e;
    int   lows;
    logic rd_leak;
    cyc(0, 1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h30, 32'h0);
    exp_q.push_back('{1'b0, 1'b0, 32'h0});
    lows = 0;
    cyc(0, 0, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'h12345678);
    while (hreadyin === 1'b0 && lows < 20) begin
      lows++;
      cyc(0, 0, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'h12345678);
    end
    checks++;
    if (lows != 3) begin
      errors++;
      $display("FAIL wait_write_stall: low cycles=%0d expected 3", lows);
    end
    e = exp_q.pop_front();
    checks++;
    if ({hreadyin, hresp} !== {1'b1, e.err}) begin
      errors++;
      $display("FAIL wait_write_done: ready/resp=%b%b expected 1%b", hreadyin, hresp, e.err);
    end

    cyc(0, 1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h30, 32'h0);
    exp_q.push_back('{1'b1, 1'b0, 32'h12345678});
    lows = 0;
    rd_leak = 1'b0;
    cyc(0, 0, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'h0);
    while (hreadyin === 1'b0 && lows < 20) begin
      lows++;
      if (hrdata !== 32'h0) rd_leak = 1'b1;
      cyc(0, 0, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'h0);
    end
    checks++;
    if (lows + 1 != 4) begin
      errors++;
      $display("FAIL wait_read_cycles: data-phase cycles=%0d expected 4", lows + 1);
    end
    checks++;
    if (rd_leak !== 1'b0) begin
      errors++;
      $display("FAIL wait_hrdata_zero: nonzero hrdata seen during wait, expected 0");
    end
    e = exp_q.pop_front();
    checks++;
    if ({hreadyin, hresp, hrdata} !== {1'b1, e.err, e.data}) begin
      errors++;
      $display("FAIL wait_read_data: ready=%b resp=%b data=%h expected ready=1 resp=%b data=%h",
               hreadyin, hresp, hrdata, e.err, e.data);
    end
  endtask

  task automatic test_error();
    exp_t        e;
    logic [31:0] ad [3];
    logic [2:0]  sz [3];
    ad = '{32'h02, 32'h00, 32'h01};
    sz = '{HSIZE_WORD, 3'd3, HSIZE_HALF};
    cyc(1, 0, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h00, 32'h0);
    cyc(0, 0, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'hA5A5A5A5);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, HTRANS_NONSEQ, 1, sz[i], ad[i], 32'h0);
      exp_q.push_back('{1'b0, 1'b1, 32'h0});
      cyc(0, 0, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'hFFFFFFFF);
      e = exp_q.pop_front();
      checks++;
      if ({hreadyin, hresp} !== {1'b0, e.err}) begin
        errors++;
        $display("FAIL err1[%0d]: ready/resp=%b%b expected 0%b", i, hreadyin, hresp, e.err);
      end
      cyc(0, 0, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'hFFFFFFFF);
      checks++;
      if ({hreadyin, hresp} !== {1'b1, e.err}) begin
        errors++;
        $display("FAIL err2[%0d]: ready/resp=%b%b expected 1%b", i, hreadyin, hresp, e.err);
      end
    end
    cyc(1, 0, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h00, 32'h0);
    exp_q.push_back('{1'b1, 1'b0, 32'hA5A5A5A5});
    cyc(0, 0, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'h0);
    e = exp_q.pop_front();
    checks++;
    if ({hreadyin, hresp, hrdata} !== {1'b1, e.err, e.data}) begin
      errors++;
      $display("FAIL err_readback: ready=%b resp=%b data=%h expected ready=1 resp=%b data=%h",
               hreadyin, hresp, hrdata, e.err, e.data);
    end
  endtask

  task automatic test_stray();
    exp_t       e;
    logic       s0 [3];
    logic [1:0] tr [3];
    s0 = '{1'b1, 1'b1, 1'b0};
    tr = '{HTRANS_BUSY, HTRANS_IDLE, HTRANS_NONSEQ};
    for (int i = 0; i <= 3; i++) begin
      if (i < 3) cyc(s0[i], 0, tr[i], 1, HSIZE_WORD, 32'h10, 32'hFFFFFFFF);
      else       cyc(0, 0, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'hFFFFFFFF);
      checks++;
      if ({hreadyin, hresp} !== 2'b10) begin
        errors++;
        $display("FAIL stray[%0d]: ready/resp=%b%b expected 10", i, hreadyin, hresp);
      end
    end
    cyc(1, 0, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h10, 32'h0);
    exp_q.push_back('{1'b1, 1'b0, 32'hDEADBEEF});
    cyc(0, 0, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'h0);
    e = exp_q.pop_front();
    checks++;
    if ({hreadyin, hresp, hrdata} !== {1'b1, e.err, e.data}) begin
      errors++;
      $display("FAIL stray_readback: ready=%b resp=%b data=%h expected ready=1 resp=%b data=%h",
               hreadyin, hresp, hrdata, e.err, e.data);
    end
  endtask

  task automatic test_reset_in_wait();
    exp_t e;
    int   lows;
    cyc(0, 1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h30, 32'h0);
    cyc(0, 0, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'h99999999);
    checks++;
    if (hreadyin !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait_entry: ready=%b expected 0", hreadyin);
    end
    #2 hreset = 1'b1;
    #1;
    checks++;
    if ({hreadyin, hresp, hrdata} !== {1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL rst_async: ready=%b resp=%b data=%h expected ready=1 resp=0 data=00000000",
               hreadyin, hresp, hrdata);
    end
    @(posedge hclk);
    #1 hreset = 1'b0;
    @(negedge hclk);

    cyc(0, 1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h30, 32'h0);
    exp_q.push_back('{1'b1, 1'b0, 32'h12345678});
    lows = 0;
    cyc(0, 0, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'h0);
    while (hreadyin === 1'b0 && lows < 20) begin
      lows++;
      cyc(0, 0, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'h0);
    end
    checks++;
    if (lows != 3) begin
      errors++;
      $display("FAIL rst_next_stall: low cycles=%0d expected 3", lows);
    end
    e = exp_q.pop_front();
    checks++;
    if ({hreadyin, hresp, hrdata} !== {1'b1, e.err, e.data}) begin
      errors++;
      $display("FAIL rst_keeps_old: ready=%b resp=%b data=%h expected ready=1 resp=%b data=%h",
               hreadyin, hresp, hrdata, e.err, e.data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_word_rw();
    test_back_to_back();
    test_byte_lanes();
    test_wait_states();
    test_error();
    test_stray();
    test_reset_in_wait();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
